// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, default parameters and divider helpers
//                used by the transmitter and receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int C_DEF_BAUD_RATE = 9600;
    localparam int C_DEF_CLK_FREQ  = 100_000_000;
    localparam int C_DEF_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per bit, truncated.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Width of a counter holding 0..div-1, never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Free-running bit-period down-counter. Reloads DIV-1 on
//                restart or after reaching zero; bit_tick marks the last
//                cycle of each bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV   = 10416,
    parameter int CNT_W = 14
) (
    input  logic clk,
    input  logic arst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count down once per clock; a restart re-aligns the period to the new frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == '0)) begin
            r_cnt <= C_RELOAD;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign bit_tick = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter, 1 start bit, DATA_BITS data bits LSB
//                first, no parity, 1 stop bit. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE = C_DEF_BAUD_RATE,
    parameter int CLK_FREQ  = C_DEF_CLK_FREQ,
    parameter int DATA_BITS = C_DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_serial
);

    localparam int             C_DIV      = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int             C_CNT_W    = cnt_width(C_DIV);
    localparam logic [3:0]     C_LAST_BIT = 4'(DATA_BITS - 1);

    uart_state_e          r_state,   w_state_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic [3:0]           r_bit_idx, w_bit_idx_nxt;
    logic                 r_serial,  w_serial_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic                 r_done,    w_done_nxt;
    logic                 w_restart;
    logic                 w_bit_tick;

    uart_baud_gen #(
        .DIV   (C_DIV),
        .CNT_W (C_CNT_W)
    ) u_baud_gen (
        .clk      (clk),
        .arst_n   (arst_n),
        .restart  (w_restart),
        .bit_tick (w_bit_tick)
    );

    // State and output registers; reset forces an idle line and drops any frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_serial  <= w_serial_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic; every bit boundary is a baud tick, outputs are precomputed
    // so the registered line changes on the same edge as the state.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_serial_nxt  = r_serial;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_restart     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_serial_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (tx_en) begin
                    w_state_nxt  = START;
                    w_shift_nxt  = tx_data;
                    w_serial_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_restart    = 1'b1;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = '0;
                    w_serial_nxt  = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == C_LAST_BIT) begin
                        w_state_nxt  = STOP;
                        w_serial_nxt = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                        w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_serial_nxt  = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_state_nxt  = IDLE;
                    w_serial_nxt = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Expected frames are queued
//                as they are requested and compared against the line as it
//                is sampled at mid-bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int A_DIV   = 16;                  // 1_600_000 / 100_000
    localparam int A_FRAME = 10 * A_DIV;
    localparam int B_DIV   = 434;                 // 50_000_000 / 115_200

    logic       clk;
    logic       arst_n;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy, tx_done, tx_serial;
    logic       b_en;
    logic [6:0] b_data;
    logic       b_busy, b_done, b_serial;

    int         vectors     = 0;
    int         miscompares = 0;
    bit         mon_en      = 1'b0;
    int         last_gap    = 0;
    int         done_seen   = 0;
    logic [9:0] sb[$];

    uart_tx #(.BAUD_RATE(100_000), .CLK_FREQ(1_600_000), .DATA_BITS(8)) dut_a (
        .clk       (clk),
        .arst_n    (arst_n),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_serial (tx_serial)
    );

    uart_tx #(.BAUD_RATE(115_200), .CLK_FREQ(50_000_000), .DATA_BITS(7)) dut_b (
        .clk       (clk),
        .arst_n    (arst_n),
        .tx_en     (b_en),
        .tx_data   (b_data),
        .tx_busy   (b_busy),
        .tx_done   (b_done),
        .tx_serial (b_serial)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (tx_done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
    endtask

    // Line monitor: on a start bit, sample every bit at mid-period and score it.
    initial begin : monitor
        logic [9:0] frame;
        logic [9:0] expf;
        frame = '0;
        forever begin
            @(negedge clk);
            if (mon_en && arst_n === 1'b1 && tx_serial === 1'b0) begin
                repeat (A_DIV / 2) @(negedge clk);
                frame[0] = tx_serial;
                for (int k = 1; k < 10; k++) begin
                    repeat (A_DIV) @(negedge clk);
                    frame[k] = tx_serial;
                end
                check("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    expf = sb.pop_front();
                    check("frame_bits", 32'(frame), 32'(expf));
                end
            end
        end
    end

    // Busy/done tracker: busy length per frame, done pulse shape, idle gap.
    initial begin : tracker
        int   busy_cnt;
        int   idle_cnt;
        logic prev_busy;
        busy_cnt  = 0;
        idle_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_busy === 1'b1) begin
                if (!prev_busy) last_gap = idle_cnt;
                idle_cnt = 0;
                busy_cnt++;
            end else begin
                if (prev_busy && mon_en) check("busy_cycles", 32'(busy_cnt), 32'(A_FRAME));
                busy_cnt = 0;
                idle_cnt++;
            end
            if (mon_en && (tx_done === 1'b1 || (prev_busy && tx_busy !== 1'b1)))
                check("done_pulse", 32'(tx_done), 32'(prev_busy && tx_busy !== 1'b1));
            if (tx_done === 1'b1) done_seen++;
            prev_busy = (tx_busy === 1'b1);
        end
    end

    initial begin : watchdog
        #(10 * 50_000);
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int         done_base;
        bit         line_high;
        logic [8:0] bframe;
        int         done_at;

        arst_n  = 1'b0;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        b_en    = 1'b0;
        b_data  = 7'h00;

        // Reset state
        #100;
        check("rst_serial", 32'(tx_serial), 32'd1);
        check("rst_busy",   32'(tx_busy),   32'd0);
        check("rst_done",   32'(tx_done),   32'd0);
        check("rst_b_serial", 32'(b_serial), 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_serial", 32'(tx_serial), 32'd1);
        mon_en = 1'b1;

        // 0x55 with tx_en held for two cycles
        sb.push_back({1'b1, 8'h55, 1'b0});
        tx_data = 8'h55;
        tx_en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_en   = 1'b0;
        tx_data = 8'hFF;
        wait_done("done_55", A_FRAME + 10);
        repeat (20) @(negedge clk);

        // 0xAF 200 ns after done, data changed while in flight
        sb.push_back({1'b1, 8'hAF, 1'b0});
        tx_data = 8'hAF;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (3 * A_DIV) @(negedge clk);
        tx_data = 8'h5A;
        wait_done("done_af", A_FRAME + 10);
        repeat (20) @(negedge clk);

        // tx_en pulse in the middle of a frame is ignored
        sb.push_back({1'b1, 8'h3C, 1'b0});
        tx_data = 8'h3C;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (5 * A_DIV + A_DIV / 2) @(negedge clk);
        tx_data = 8'hFF;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        check("busy_midframe", 32'(tx_busy), 32'd1);
        wait_done("done_3c", A_FRAME);
        repeat (12 * A_DIV) @(negedge clk);
        check("no_extra_busy", 32'(tx_busy), 32'd0);
        check("sb_empty_1", 32'(sb.size()), 32'd0);

        // tx_en held high: back-to-back frames with a one-cycle gap
        done_base = done_seen;
        for (int i = 0; i < 3; i++) sb.push_back({1'b1, 8'h00, 1'b0});
        tx_data = 8'h00;
        tx_en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done("done_held", A_FRAME + 10);
            if (i == 2) tx_en = 1'b0;
            @(negedge clk);
        end
        check("held_gap", 32'(last_gap), 32'd1);
        repeat (12 * A_DIV) @(negedge clk);
        check("held_done_count", 32'(done_seen - done_base), 32'd3);
        check("sb_empty_2", 32'(sb.size()), 32'd0);
        check("held_idle_busy", 32'(tx_busy), 32'd0);

        // Asynchronous reset in the middle of a frame
        mon_en  = 1'b0;
        tx_data = 8'h00;
        tx_en   = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (3 * A_DIV) @(negedge clk);
        check("pre_rst_serial", 32'(tx_serial), 32'd0);
        check("pre_rst_busy",   32'(tx_busy),   32'd1);
        #2 arst_n = 1'b0;
        #1;
        check("async_rst_serial", 32'(tx_serial), 32'd1);
        check("async_rst_busy",   32'(tx_busy),   32'd0);
        check("async_rst_done",   32'(tx_done),   32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        line_high = 1'b1;
        for (int c = 0; c < 12 * A_DIV; c++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) line_high = 1'b0;
        end
        check("no_resume", 32'(line_high), 32'd1);

        // DATA_BITS=7 at 50 MHz / 115200: 9*434 cycles, MSB as bit 6
        bframe  = '0;
        done_at = -1;
        b_data  = 7'h41;
        b_en    = 1'b1;
        @(negedge clk);
        b_en   = 1'b0;
        b_data = 7'h00;
        for (int c = 0; c < 9 * B_DIV + 20; c++) begin
            if ((c % B_DIV) == (B_DIV / 2) && (c / B_DIV) < 9) bframe[c / B_DIV] = b_serial;
            if (b_done === 1'b1 && done_at < 0) done_at = c;
            @(negedge clk);
        end
        check("b_frame",   32'(bframe),    32'({1'b1, 7'h41, 1'b0}));
        check("b_msb",     32'(bframe[7]), 32'd1);
        check("b_done_at", 32'(done_at),   32'(9 * B_DIV));
        check("b_idle",    32'(b_busy),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
